puf_soc_resp_tx: RTL and testbench
==================================

# puf_soc_resp_tx

Response transmitter for the PUF SoC. It sits on the transmit side of the SoC controller and answers that controller's `o_tx_enable` / `i_tx_done` handshake. On each transmit request it captures the response word, serializes it as a sequence of UART 8N1 frames on a single output line, then returns a one-cycle done pulse. It is the outbound counterpart to the command path that delivers `i_rx_data` into the controller.

## Interface
Parameters:
- `RESP_BIT_SIZE`, default 40: response word width; must be a multiple of 8. `NUM_BYTES = RESP_BIT_SIZE/8`.
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; minimum 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_tx_enable`  in  1  transmit request level; driven by the controller's `o_tx_enable`.
- `i_sft_rst`  in  1  synchronous soft reset/abort; driven by the controller's `o_sft_rst`.
- `i_resp_data`  in  `RESP_BIT_SIZE`  response word; sampled only at transfer start.
- `o_uart_tx`  out  1  serial line; idles high.
- `o_tx_busy`  out  1  high while a transfer is in progress.
- `o_tx_done`  out  1  one-cycle pulse after the last stop bit; feeds the controller's `i_tx_done`.

## Operation
- States: IDLE, START, DATA, (PARITY), STOP, DONE, WAIT_LOW.
- IDLE → START when `i_tx_enable`=1, the block is armed, and `i_sft_rst`=0. On that edge:
  - latch `i_resp_data` into the shift register;
  - clear the byte index and bit counter;
  - drive `o_uart_tx` to 0.
- Frame format, LSB first:
  - START: 1 bit at 0;
  - DATA: 8 bits;
  - PARITY: 1 bit, only when enabled (see Configuration);
  - STOP: 1 bit at 1.
- Byte order: byte 0 (`[7:0]`) first, up to byte `NUM_BYTES-1`.
- STOP of a non-final byte → START of the next byte directly, with no idle gap.
- STOP of the final byte → DONE. DONE lasts exactly one cycle with `o_tx_done`=1, then goes to WAIT_LOW.
- WAIT_LOW → IDLE once `i_tx_enable`=0 is sampled. This rearm rule means a level held high through the done cycle never causes a second transfer.
- Dropping `i_tx_enable` mid-transfer is ignored; the transfer completes and still produces `o_tx_done`.
- `i_sft_rst`=1 in any state, on the next edge:
  - go to IDLE, armed;
  - `o_uart_tx`=1, `o_tx_busy`=0;
  - no done pulse.
- If `i_sft_rst` and a start condition occur in the same cycle, `i_sft_rst` wins.
- Bit counter: width `$clog2(CLKS_PER_BIT)`. It wraps to 0 at `CLKS_PER_BIT-1` and advances the bit position at that point.
- Byte index: width `$clog2(NUM_BYTES+1)`.

## Timing
- Values during reset and after soft reset:
  - `o_uart_tx`=1, `o_tx_busy`=0, `o_tx_done`=0;
  - state IDLE, armed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start edge E0: `o_uart_tx` and `o_tx_busy` change on E0 itself.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length F = 10 bits, or 11 with parity.
- `o_tx_done` rises at E0 + `NUM_BYTES`·F·`CLKS_PER_BIT` cycles and stays high for one cycle.
- `o_tx_busy` falls on the same edge that `o_tx_done` rises.
- Earliest restart: one cycle after `i_tx_enable` is sampled low in WAIT_LOW.

## Configuration
- Macro `PUF_TX_PARITY_EN`:
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted after DATA; F=11.
  - Undefined: the PARITY state and its logic are absent; F=10.

## Structure
- Shared package `puf_soc_pkg` holds:
  - the TX state enum;
  - `UART_IDLE_LVL`=1'b1;
  - `FRAME_BITS`, a function of `PUF_TX_PARITY_EN`.
- Sub-module `puf_uart_tx_byte`: one-byte serializer with baud counter and start/data/parity/stop sequencing, handshaked by `load`/`byte_done`.
- The top level owns:
  - word capture;
  - byte sequencing;
  - the done/rearm FSM;
  - soft-reset handling.

## Test plan
Use `CLKS_PER_BIT`=4 and `RESP_BIT_SIZE`=40 for all scenarios.
- Single transfer: `i_resp_data`=40'h00_0000_00A5, enable held high.
  - Line shows byte 0 bits 1,0,1,0,0,1,0,1 (LSB first) between start/stop, then four 0x00 frames.
  - `o_tx_done` pulses exactly at E0+200 cycles.
- Held enable: `i_tx_enable` kept high for 500 cycles after done → exactly one transfer; line stays 1 after done.
- Back-to-back: drop enable for one cycle after done, then raise it with 40'h12_3456_789A.
  - Second transfer starts within 2 cycles.
  - Bytes observed in order 9A,78,56,34,12.
- Soft-reset abort: assert `i_sft_rst` at cycle 50 of a transfer.
  - Next cycle: `o_uart_tx`=1, `o_tx_busy`=0.
  - No `o_tx_done`.
  - A new enable restarts cleanly.
- Async reset mid-frame: pulse `rst_n` low at cycle 30 → outputs go to 1/0/0 immediately, without waiting for a clock edge.
- Parity build with `PUF_TX_PARITY_EN`: data byte 8'h07 → parity bit 1; done pulse at E0+220 cycles.

Source files
------------

// File: rtl/puf_soc_pkg.sv
// Shared definitions for the PUF SoC response transmit path.
// Optional feature macro: PUF_TX_PARITY_EN (adds an even-parity bit per UART frame).
package puf_soc_pkg;

  // Level the UART line rests at between frames and after any reset.
  localparam logic UART_IDLE_LVL = 1'b1;

  // Bits per UART frame: start + 8 data + optional parity + stop.
`ifdef PUF_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Transmit state encoding. The byte serializer walks START/DATA/PARITY/STOP;
  // the top-level sequencer uses IDLE/START/DONE/WAIT_LOW.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef PUF_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP,
    TX_DONE,
    TX_WAIT_LOW
  } tx_state_t;

  // Even parity of a data byte: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/puf_uart_tx_byte.sv
// One-byte UART serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// A load pulse starts a frame on the same edge (line goes low immediately); byte_done
// is high during the final cycle of the stop bit so the caller can chain the next
// byte with no idle gap. abort returns the line to idle on the next edge.
// Optional feature macro: PUF_TX_PARITY_EN.
module puf_uart_tx_byte
  import puf_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       data_sh_reg;
  logic             tx_reg;
`ifdef PUF_TX_PARITY_EN
  logic             parity_reg;
`endif

  logic bit_end;

  assign bit_end   = (cnt_reg == CNT_MAX);
  assign byte_done = (state_reg == TX_STOP) && bit_end;
  assign tx        = tx_reg;

  // Baud counter and frame sequencing; the line level is registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= TX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      data_sh_reg <= '0;
      tx_reg      <= UART_IDLE_LVL;
`ifdef PUF_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else if (abort) begin
      state_reg   <= TX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= UART_IDLE_LVL;
    end else if (load) begin
      // New frame begins on this edge: start bit goes out right away.
      state_reg   <= TX_START;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      data_sh_reg <= data;
      tx_reg      <= 1'b0;
`ifdef PUF_TX_PARITY_EN
      parity_reg  <= even_parity(data);
`endif
    end else if (state_reg == TX_IDLE) begin
      cnt_reg <= '0;
      tx_reg  <= UART_IDLE_LVL;
    end else if (!bit_end) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else begin
      cnt_reg <= '0;
      case (state_reg)
        TX_START: begin
          state_reg <= TX_DATA;
          tx_reg    <= data_sh_reg[0];
        end
        TX_DATA: begin
          if (bit_idx_reg == 3'd7) begin
`ifdef PUF_TX_PARITY_EN
            state_reg <= TX_PARITY;
            tx_reg    <= parity_reg;
`else
            state_reg <= TX_STOP;
            tx_reg    <= UART_IDLE_LVL;
`endif
          end else begin
            bit_idx_reg <= bit_idx_reg + 1'b1;
            data_sh_reg <= data_sh_reg >> 1;
            tx_reg      <= data_sh_reg[1];
          end
        end
`ifdef PUF_TX_PARITY_EN
        TX_PARITY: begin
          state_reg <= TX_STOP;
          tx_reg    <= UART_IDLE_LVL;
        end
`endif
        TX_STOP: begin
          // Without a chained load the line simply stays idle.
          state_reg <= TX_IDLE;
          tx_reg    <= UART_IDLE_LVL;
        end
        default: begin
          state_reg <= TX_IDLE;
          tx_reg    <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: rtl/puf_soc_resp_tx.sv
// PUF SoC response transmitter: captures the response word on a transmit request,
// sends it byte 0 first as back-to-back UART frames, pulses o_tx_done for one cycle,
// then waits for the request level to drop before it can start again.
// Optional feature macro: PUF_TX_PARITY_EN (frames carry an even-parity bit).
module puf_soc_resp_tx
  import puf_soc_pkg::*;
#(
  parameter int RESP_BIT_SIZE = 40,
  parameter int CLKS_PER_BIT  = 868
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_tx_enable,
  input  logic                     i_sft_rst,
  input  logic [RESP_BIT_SIZE-1:0] i_resp_data,
  output logic                     o_uart_tx,
  output logic                     o_tx_busy,
  output logic                     o_tx_done
);

  localparam int NUM_BYTES = RESP_BIT_SIZE / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // In this FSM TX_START covers the whole serialization of the word; the
  // per-bit phases live inside the byte serializer.
  tx_state_t                state_reg;
  logic [RESP_BIT_SIZE-1:0] shift_reg;     // bytes not yet handed to the serializer, next one in [7:0]
  logic [IDX_W-1:0]         byte_idx_reg;  // index of the byte currently on the line
  logic                     busy_reg;
  logic                     done_reg;

  logic       start_cond;
  logic       last_byte;
  logic       next_load;
  logic       ser_load;
  logic [7:0] ser_data;
  logic       byte_done;

  // Soft reset always wins over a start request in the same cycle.
  assign start_cond = (state_reg == TX_IDLE) && i_tx_enable && !i_sft_rst;
  assign last_byte  = (byte_idx_reg == LAST_IDX);
  assign next_load  = (state_reg == TX_START) && byte_done && !last_byte && !i_sft_rst;
  assign ser_load   = start_cond || next_load;
  // Byte 0 comes straight from the input so the start bit can leave on the request edge.
  assign ser_data   = start_cond ? i_resp_data[7:0] : shift_reg[7:0];

  puf_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (i_sft_rst),
    .load      (ser_load),
    .data      (ser_data),
    .tx        (o_uart_tx),
    .byte_done (byte_done)
  );

  // Word capture, byte sequencing, done pulse and rearm handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= TX_IDLE;
      shift_reg    <= '0;
      byte_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else if (i_sft_rst) begin
      state_reg    <= TX_IDLE;
      byte_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        TX_IDLE: begin
          if (start_cond) begin
            state_reg    <= TX_START;
            shift_reg    <= i_resp_data >> 8;
            byte_idx_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        TX_START: begin
          if (byte_done) begin
            if (last_byte) begin
              state_reg <= TX_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
              shift_reg    <= shift_reg >> 8;
            end
          end
        end
        TX_DONE: begin
          state_reg <= TX_WAIT_LOW;
        end
        TX_WAIT_LOW: begin
          // A request level still high from the previous transfer must not retrigger.
          if (!i_tx_enable) begin
            state_reg <= TX_IDLE;
          end
        end
        default: begin
          state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_tx_busy = busy_reg;
  assign o_tx_done = done_reg;

endmodule

// File: tb/tb_puf_soc_resp_tx.sv
// Scoreboard bench for puf_soc_resp_tx: stimulus pushes the expected byte sequence
// and done time; a UART receiver monitor and a done monitor pop and compare.
module tb_puf_soc_resp_tx;

  localparam int C  = 4;
  localparam int W  = 40;
  localparam int NB = W / 8;
`ifdef PUF_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_tx_enable = 1'b0;
  logic         i_sft_rst = 1'b0;
  logic [W-1:0] i_resp_data = '0;
  logic         o_uart_tx;
  logic         o_tx_busy;
  logic         o_tx_done;

  puf_soc_resp_tx #(
    .RESP_BIT_SIZE(W),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tx_enable(i_tx_enable),
    .i_sft_rst  (i_sft_rst),
    .i_resp_data(i_resp_data),
    .o_uart_tx  (o_uart_tx),
    .o_tx_busy  (o_tx_busy),
    .o_tx_done  (o_tx_done)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0] exp_bytes[$];
  int         exp_done[$];
  int         abort_gen = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Reference model: a transfer is the word's bytes in order 0..NB-1, done after NB frames.
  task automatic expect_word(input logic [W-1:0] data, input int e0);
    for (int b = 0; b < NB; b++) exp_bytes.push_back(data[8*b +: 8]);
    exp_done.push_back(e0 + NB * FR * C);
  endtask

  task automatic flush_expect();
    abort_gen++;
    exp_bytes.delete();
    exp_done.delete();
  endtask

  // Issue one transfer from a negedge with the DUT idle; wait for done, optionally
  // hold the request high afterwards, then rearm by dropping the request one cycle.
  task automatic do_transfer(input logic [W-1:0] data, input bit drop_mid, input int hold_cycles);
    int e0;
    int waited;
    int bad;
    logic [63:0] junk;
    i_resp_data = data;
    i_tx_enable = 1'b1;
    e0 = cycle + 1;
    expect_word(data, e0);
    $display("transfer data=%010h start=%0d drop_mid=%0d hold=%0d", data, e0, drop_mid, hold_cycles);
    @(negedge clk);
    check("start_line", {63'd0, o_uart_tx}, 64'd0);
    check("start_busy", {63'd0, o_tx_busy}, 64'd1);
    junk = {$urandom, $urandom};
    i_resp_data = junk[W-1:0];
    if (drop_mid) begin
      repeat ($urandom_range(1, 100)) @(negedge clk);
      i_tx_enable = 1'b0;
    end
    waited = 0;
    while (!o_tx_done && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", {63'd0, o_tx_done}, 64'd1);
    check("busy_fall", {63'd0, o_tx_busy}, 64'd0);
    if (hold_cycles > 0) begin
      bad = 0;
      repeat (hold_cycles) begin
        @(negedge clk);
        if (o_uart_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
      end
      check("hold_idle", bad, 0);
    end
    @(negedge clk);
    i_tx_enable = 1'b0;
    @(negedge clk);
  endtask

  // UART receiver monitor: decodes each frame at mid-bit and checks it against the queue.
  initial begin
    int g;
    logic sbit, stbit, pbit;
    logic [7:0] rx, e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_uart_tx === 1'b0) begin
        g = abort_gen;
        repeat (C / 2) @(negedge clk);
        sbit = o_uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          rx[i] = o_uart_tx;
        end
        pbit = 1'b0;
`ifdef PUF_TX_PARITY_EN
        repeat (C) @(negedge clk);
        pbit = o_uart_tx;
`endif
        repeat (C) @(negedge clk);
        stbit = o_uart_tx;
        if (g == abort_gen) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %02h required none", rx);
          end else begin
            e = exp_bytes.pop_front();
            $display("frame byte=%02h expected=%02h", rx, e);
            check("frame_start", {63'd0, sbit}, 64'd0);
            check("frame_byte", {56'd0, rx}, {56'd0, e});
            check("frame_stop", {63'd0, stbit}, 64'd1);
`ifdef PUF_TX_PARITY_EN
            check("frame_parity", {63'd0, pbit}, {63'd0, ^e});
`else
            if (pbit !== 1'b0) $display("parity sample unused");
`endif
          end
        end
      end
    end
  end

  // Done monitor: every done pulse must match the next expected done cycle.
  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (o_tx_done === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got pulse at cycle %0d required none", cycle);
        end else begin
          t = exp_done.pop_front();
          check("done_time", cycle, t);
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    int e0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_line", {63'd0, o_uart_tx}, 64'd1);
    check("rst_busy", {63'd0, o_tx_busy}, 64'd0);
    check("rst_done", {63'd0, o_tx_done}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single transfer of 0xA5, request held high 500 cycles past done
    do_transfer(40'h00_0000_00A5, 1'b0, 500);

    // Back-to-back after a one-cycle drop
    do_transfer(40'h12_3456_789A, 1'b0, 0);

    // Randomized transfers with random gaps and random mid-transfer request drops
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      r = {$urandom, $urandom};
      do_transfer(r[W-1:0], 1'($urandom_range(0, 1)), 0);
    end

    // Soft-reset abort at cycle 50 of a transfer
    r = {$urandom, $urandom};
    i_resp_data = r[W-1:0];
    i_tx_enable = 1'b1;
    e0 = cycle + 1;
    expect_word(r[W-1:0], e0);
    $display("transfer data=%010h start=%0d soft-abort at +50", r[W-1:0], e0);
    repeat (49) @(negedge clk);
    i_sft_rst = 1'b1;
    i_tx_enable = 1'b0;
    // Byte 0 has completed by now; the rest of the word and the done pulse must never appear.
    exp_bytes.delete();
    exp_done.delete();
    abort_gen++;
    @(negedge clk);
    check("sft_line", {63'd0, o_uart_tx}, 64'd1);
    check("sft_busy", {63'd0, o_tx_busy}, 64'd0);
    i_sft_rst = 1'b0;
    repeat (60) @(negedge clk);
    r = {$urandom, $urandom};
    do_transfer(r[W-1:0], 1'b0, 0);

    // Asynchronous reset mid-frame; byte 0 = 0x00 so the line is low just before
    i_resp_data = 40'hFF_FFFF_FF00;
    i_tx_enable = 1'b1;
    e0 = cycle + 1;
    expect_word(40'hFF_FFFF_FF00, e0);
    $display("transfer data=ffffffff00 start=%0d async reset at +30", e0);
    repeat (30) @(negedge clk);
    check("pre_rst_line", {63'd0, o_uart_tx}, 64'd0);
    #1;
    rst_n = 1'b0;
    i_tx_enable = 1'b0;
    flush_expect();
    #1;
    check("arst_line", {63'd0, o_uart_tx}, 64'd1);
    check("arst_busy", {63'd0, o_tx_busy}, 64'd0);
    check("arst_done", {63'd0, o_tx_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    r = {$urandom, $urandom};
    do_transfer(r[W-1:0], 1'b0, 0);

    // Everything expected must have been observed
    repeat (60) @(negedge clk);
    check("bytes_drained", exp_bytes.size(), 0);
    check("done_drained", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
